// File: rtl/exec_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU opcodes, operand
// forwarding selects, ALU-B source selects and the MUL handshake states.
package exec_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  localparam logic [1:0] FWD_EX   = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_ZERO = 2'd3;

  localparam logic [1:0] SRC_DB    = 2'd0;
  localparam logic [1:0] SRC_IMM12 = 2'd1;
  localparam logic [1:0] SRC_IMM9  = 2'd2;
  localparam logic [1:0] SRC_ZERO  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } exec_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH steps,
// low WIDTH bits of the product kept.
module mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;

  // NOTE: the datapath registers are reset too, so a product left over from an
  // aborted run can never appear on o_product after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_mcand  <= i_multiplicand;
      r_mplier <= i_multiplier;
      r_prod   <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  assign o_busy    = (r_cnt != '0);
  // The step on the edge that ends this cycle is the last one.
  assign o_done    = (r_cnt == CW'(1));
  assign o_product = r_prod;

endmodule

// File: rtl/execute_stage_mc.sv
// Multi-cycle execute stage: forwarding/ALU-source muxes, single-cycle ALU with
// flags, and a stall/done handshake around the iterative multiplier.
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ExValid,
  input  logic             ExMul,
  input  logic             ExFlush,
  input  logic [WIDTH-1:0] ExDa,
  input  logic [WIDTH-1:0] ExDb,
  input  logic [WIDTH-1:0] ExImm12Ext,
  input  logic [WIDTH-1:0] ExImm9Ext,
  input  logic [WIDTH-1:0] MemALUOut,
  input  logic [WIDTH-1:0] WbMemDataToReg,
  input  logic [1:0]       ForwardDa,
  input  logic [1:0]       ForwardDb,
  input  logic [1:0]       ExALUSrc,
  input  logic [2:0]       ExALUOp,
  output logic [WIDTH-1:0] ExALUOut,
  output logic [WIDTH-1:0] ExFwdDb,
  output logic             ExNegative,
  output logic             ExZero,
  output logic             ExOverflow,
  output logic             ExCarryout,
  output logic             ExStall,
  output logic             ExOutValid
);

  localparam int MSB = WIDTH - 1;

  exec_state_t r_state;
  exec_state_t w_state_next;

  logic [WIDTH-1:0] w_fwd_da;
  logic [WIDTH-1:0] w_fwd_db;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH:0]   w_add_full;
  logic [WIDTH:0]   w_sub_full;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic             w_carry;

  logic             w_mul_issue;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_product;
  logic             w_sel_prod;
  logic             w_stall;
  logic             w_out_valid;

  always_comb begin
    case (ForwardDa)
      FWD_EX:   w_fwd_da = ExDa;
      FWD_MEM:  w_fwd_da = MemALUOut;
      FWD_WB:   w_fwd_da = WbMemDataToReg;
      FWD_ZERO: w_fwd_da = '0;
      default:  w_fwd_da = '0;
    endcase
    case (ForwardDb)
      FWD_EX:   w_fwd_db = ExDb;
      FWD_MEM:  w_fwd_db = MemALUOut;
      FWD_WB:   w_fwd_db = WbMemDataToReg;
      FWD_ZERO: w_fwd_db = '0;
      default:  w_fwd_db = '0;
    endcase
    case (ExALUSrc)
      SRC_DB:    w_alu_b = w_fwd_db;
      SRC_IMM12: w_alu_b = ExImm12Ext;
      SRC_IMM9:  w_alu_b = ExImm9Ext;
      SRC_ZERO:  w_alu_b = '0;
      default:   w_alu_b = '0;
    endcase
  end

  // Subtraction is A + ~B + 1 so the carry reads as "no borrow".
  assign w_add_full = {1'b0, w_fwd_da} + {1'b0, w_alu_b};
  assign w_sub_full = {1'b0, w_fwd_da} + {1'b0, ~w_alu_b} + {{WIDTH{1'b0}}, 1'b1};

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    w_carry    = 1'b0;
    case (ExALUOp)
      ALU_PASS_B: w_result = w_alu_b;
      ALU_ADD: begin
        {w_carry, w_result} = w_add_full;
        w_overflow = (w_fwd_da[MSB] == w_alu_b[MSB]) && (w_add_full[MSB] != w_fwd_da[MSB]);
      end
      ALU_SUB: begin
        {w_carry, w_result} = w_sub_full;
        w_overflow = (w_fwd_da[MSB] != w_alu_b[MSB]) && (w_sub_full[MSB] != w_fwd_da[MSB]);
      end
      ALU_AND: w_result = w_fwd_da & w_alu_b;
      ALU_OR:  w_result = w_fwd_da | w_alu_b;
      ALU_XOR: w_result = w_fwd_da ^ w_alu_b;
      default: w_result = '0;
    endcase
    if (w_sel_prod) begin
      w_result   = w_product;
      w_overflow = 1'b0;
      w_carry    = 1'b0;
    end
  end

  assign w_mul_issue = (MUL_EN != 0) && ExValid && ExMul && !ExFlush;

  generate
    if (MUL_EN != 0) begin : g_mul
      mul_iter #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk            (clk),
        .rst_n          (reset),
        .i_start        (w_mul_start),
        .i_abort        (ExFlush),
        .i_multiplicand (w_fwd_da),
        .i_multiplier   (w_alu_b),
        .o_busy         (w_mul_busy),
        .o_done         (w_mul_done),
        .o_product      (w_product)
      );
    end else begin : g_no_mul
      assign w_mul_busy = 1'b0;
      assign w_mul_done = 1'b0;
      assign w_product  = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_out_valid  = 1'b0;
    w_mul_start  = 1'b0;
    w_sel_prod   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mul_issue) begin
          w_stall      = 1'b1;
          w_mul_start  = 1'b1;
          w_state_next = RUN;
        end else begin
          w_out_valid = ExValid;
        end
      end
      RUN: begin
        w_stall = 1'b1;
        if (w_mul_done)       w_state_next = DONE;
        else if (!w_mul_busy) w_state_next = IDLE;
      end
      DONE: begin
        // The held MUL is retired here; returning to IDLE never restarts it.
        w_out_valid  = 1'b1;
        w_sel_prod   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (ExFlush) begin
      w_stall      = 1'b0;
      w_out_valid  = 1'b0;
      w_mul_start  = 1'b0;
      w_state_next = IDLE;
    end
  end

  assign ExALUOut   = w_result;
  assign ExFwdDb    = w_fwd_db;
  assign ExNegative = w_result[MSB];
  assign ExZero     = (w_fwd_db == '0);
  assign ExOverflow = w_overflow;
  assign ExCarryout = w_carry;
  // Handshake outputs are held low for the whole time reset is asserted.
  assign ExStall    = w_stall && reset;
  assign ExOutValid = w_out_valid && reset;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc at WIDTH=8: ALU vector table plus
// hand-written MUL stall, flush and reset sequences, and a MUL_EN=0 build.
module tb_execute_stage_mc;
  import exec_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ExValid = 1'b0, ExMul = 1'b0, ExFlush = 1'b0;
  logic [W-1:0] ExDa = '0, ExDb = '0, ExImm12Ext = '0, ExImm9Ext = '0;
  logic [W-1:0] MemALUOut = '0, WbMemDataToReg = '0;
  logic [1:0]   ForwardDa = '0, ForwardDb = '0, ExALUSrc = '0;
  logic [2:0]   ExALUOp = '0;

  logic [W-1:0] out_m, fdb_m, out_n, fdb_n;
  logic         n_m, z_m, v_m, c_m, st_m, ov_m;
  logic         n_n, z_n, v_n, c_n, st_n, ov_n;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  execute_stage_mc #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .ExValid(ExValid), .ExMul(ExMul), .ExFlush(ExFlush),
    .ExDa(ExDa), .ExDb(ExDb), .ExImm12Ext(ExImm12Ext), .ExImm9Ext(ExImm9Ext),
    .MemALUOut(MemALUOut), .WbMemDataToReg(WbMemDataToReg),
    .ForwardDa(ForwardDa), .ForwardDb(ForwardDb), .ExALUSrc(ExALUSrc), .ExALUOp(ExALUOp),
    .ExALUOut(out_m), .ExFwdDb(fdb_m), .ExNegative(n_m), .ExZero(z_m),
    .ExOverflow(v_m), .ExCarryout(c_m), .ExStall(st_m), .ExOutValid(ov_m)
  );

  execute_stage_mc #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
    .clk(clk), .reset(reset), .ExValid(ExValid), .ExMul(ExMul), .ExFlush(ExFlush),
    .ExDa(ExDa), .ExDb(ExDb), .ExImm12Ext(ExImm12Ext), .ExImm9Ext(ExImm9Ext),
    .MemALUOut(MemALUOut), .WbMemDataToReg(WbMemDataToReg),
    .ForwardDa(ForwardDa), .ForwardDb(ForwardDb), .ExALUSrc(ExALUSrc), .ExALUOp(ExALUOp),
    .ExALUOut(out_n), .ExFwdDb(fdb_n), .ExNegative(n_n), .ExZero(z_n),
    .ExOverflow(v_n), .ExCarryout(c_n), .ExStall(st_n), .ExOutValid(ov_n)
  );

  typedef struct {
    logic [1:0]   fa, fb, src;
    logic [2:0]   op;
    logic [W-1:0] da, db, imm12, imm9, mem, wb;
    logic         valid, flush;
    logic [W-1:0] e_out, e_fdb;
    logic         e_n, e_z, e_v, e_c, e_ov;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ExMul = 1'b0; ExFlush = 1'b0; ExValid = 1'b1;
    ForwardDa = FWD_EX; ForwardDb = FWD_EX; ExALUSrc = SRC_DB;
    ExALUOp = op; ExDa = a; ExDb = b;
  endtask

  // Called just after the edge that opens issue cycle t; returns in cycle t+WIDTH+1.
  task automatic mul_seq(input string name, input logic [W-1:0] a, input logic [1:0] src,
                         input logic [W-1:0] db, input logic [W-1:0] imm12,
                         input logic [W-1:0] e_out, input logic e_n);
    int bad;
    ExValid = 1'b1; ExMul = 1'b1; ExFlush = 1'b0;
    ForwardDa = FWD_EX; ForwardDb = FWD_EX; ExALUSrc = src;
    ExDa = a; ExDb = db; ExImm12Ext = imm12; ExALUOp = ALU_ADD;
    #1;
    check({name, "_issue_stall"}, 0, st_m, 1);
    check({name, "_issue_valid"}, 0, ov_m, 0);
    bad = 0;
    for (int k = 1; k <= W; k++) begin
      step();
      ExDa = W'($urandom); ExDb = W'($urandom); ExImm12Ext = W'($urandom);
      MemALUOut = W'($urandom); WbMemDataToReg = W'($urandom);
      ForwardDa = 2'($urandom_range(0, 3)); ForwardDb = 2'($urandom_range(0, 3));
      ExALUSrc = 2'($urandom_range(0, 3));
      #1;
      if (st_m !== 1'b1 || ov_m !== 1'b0) bad++;
    end
    check({name, "_run_cycles_bad"}, 0, bad, 0);
    step();
    #1;
    check({name, "_done_out"}, 0, out_m, e_out);
    check({name, "_done_valid"}, 0, ov_m, 1);
    check({name, "_done_stall"}, 0, st_m, 0);
    check({name, "_done_nvc"}, 0, {n_m, v_m, c_m}, {e_n, 2'b00});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;

    //           fa fb src op          da     db     imm12  imm9   mem    wb     v  f   out    fdb    n  z  v  c  ov
    vecs[0]  = '{1, 0, 0, ALU_ADD,    8'h00, 8'h01, 8'h00, 8'h00, 8'h7F, 8'h00, 1, 0, 8'h80, 8'h01, 1, 0, 1, 0, 1};
    vecs[1]  = '{0, 0, 1, ALU_SUB,    8'h05, 8'h33, 8'h05, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h33, 0, 0, 0, 1, 1};
    vecs[2]  = '{0, 0, 0, ALU_PASS_B, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1};
    vecs[3]  = '{0, 0, 0, ALU_AND,    8'hF0, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h30, 8'h3C, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, ALU_OR,     8'hF0, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'hFC, 8'h0C, 1, 0, 0, 0, 1};
    vecs[5]  = '{0, 2, 0, ALU_XOR,    8'hFF, 8'h11, 8'h00, 8'h00, 8'h00, 8'h0F, 1, 0, 8'hF0, 8'h0F, 1, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 3'b111,     8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h34, 0, 0, 0, 0, 1};
    vecs[7]  = '{0, 0, 0, ALU_SUB,    8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h7F, 8'h01, 0, 0, 1, 1, 1};
    vecs[8]  = '{0, 0, 2, ALU_ADD,    8'hFF, 8'h05, 8'h00, 8'h01, 8'h00, 8'h00, 1, 0, 8'h00, 8'h05, 0, 0, 0, 1, 1};
    vecs[9]  = '{3, 0, 3, ALU_ADD,    8'h55, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h05, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 0, ALU_ADD,    8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h30, 8'h20, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, ALU_ADD,    8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h30, 8'h20, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 3, 0, ALU_PASS_B, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1};
    vecs[13] = '{2, 1, 0, ALU_ADD,    8'h00, 8'h00, 8'h00, 8'h00, 8'h41, 8'h40, 1, 0, 8'h81, 8'h41, 1, 0, 1, 0, 1};
    vecs[14] = '{0, 0, 0, ALU_SUB,    8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h01, 1, 0, 0, 0, 1};

    // Reset state, including a MUL request presented while reset is held.
    #2;
    check("rst_stall", 0, st_m, 0);
    check("rst_valid", 0, ov_m, 0);
    ExValid = 1'b1; ExMul = 1'b1;
    #1;
    check("rst_mul_stall", 0, st_m, 0);
    check("rst_mul_valid", 0, ov_m, 0);
    ExValid = 1'b0; ExMul = 1'b0;
    #9 reset = 1'b1;

    // Single-cycle ALU vectors.
    for (int i = 0; i < 15; i++) begin
      step();
      ExMul = 1'b0;
      ForwardDa = vecs[i].fa; ForwardDb = vecs[i].fb; ExALUSrc = vecs[i].src;
      ExALUOp = vecs[i].op; ExDa = vecs[i].da; ExDb = vecs[i].db;
      ExImm12Ext = vecs[i].imm12; ExImm9Ext = vecs[i].imm9;
      MemALUOut = vecs[i].mem; WbMemDataToReg = vecs[i].wb;
      ExValid = vecs[i].valid; ExFlush = vecs[i].flush;
      #1;
      check("alu_out", i, out_m, vecs[i].e_out);
      check("alu_fwd_db", i, fdb_m, vecs[i].e_fdb);
      check("alu_nzvc", i, {n_m, z_m, v_m, c_m}, {vecs[i].e_n, vecs[i].e_z, vecs[i].e_v, vecs[i].e_c});
      check("alu_out_valid", i, ov_m, vecs[i].e_ov);
      check("alu_stall", i, st_m, 0);
      check("nomul_alu_out", i, out_n, vecs[i].e_out);
    end

    // 0x0D x 0x0B with operands scrambled during RUN, then IDLE at t+10.
    step();
    mul_seq("mul_0d_0b", 8'h0D, SRC_DB, 8'h0B, 8'h00, 8'h8F, 1'b1);
    step();
    drive_alu(ALU_ADD, 8'h01, 8'h02);
    #1;
    check("post_mul_idle_out", 0, out_m, 8'h03);
    check("post_mul_idle_valid", 0, ov_m, 1);
    check("post_mul_idle_stall", 0, st_m, 0);

    // Truncated product, then a back-to-back MUL using the immediate as multiplier.
    step();
    mul_seq("mul_10_10", 8'h10, SRC_DB, 8'h10, 8'h00, 8'h00, 1'b0);
    step();
    mul_seq("mul_03_55", 8'h03, SRC_IMM12, 8'h00, 8'h55, 8'hFF, 1'b1);

    // Flush at t+3 of a running MUL.
    step();
    drive_alu(ALU_ADD, 8'h07, 8'h03);
    ExMul = 1'b1;
    #1;
    check("flush_issue_stall", 0, st_m, 1);
    for (int k = 1; k <= 3; k++) step();
    ExFlush = 1'b1;
    #1;
    check("flush_stall", 0, st_m, 0);
    check("flush_valid", 0, ov_m, 0);
    step();
    drive_alu(ALU_ADD, 8'h01, 8'h01);
    #1;
    check("flush_next_idle_valid", 0, ov_m, 1);
    check("flush_next_idle_stall", 0, st_m, 0);
    check("flush_next_idle_out", 0, out_m, 8'h02);
    ExValid = 1'b0;
    bad = 0;
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (ov_m !== 1'b0 || st_m !== 1'b0) bad++;
    end
    check("flush_no_late_pulse", 0, bad, 0);

    // Flush takes priority over a MUL issue in the same cycle.
    step();
    drive_alu(ALU_ADD, 8'h02, 8'h02);
    ExMul = 1'b1; ExFlush = 1'b1;
    #1;
    check("flush_prio_stall", 0, st_m, 0);
    check("flush_prio_valid", 0, ov_m, 0);
    step();
    drive_alu(ALU_ADD, 8'h02, 8'h02);
    #1;
    check("flush_prio_idle_valid", 0, ov_m, 1);
    check("flush_prio_idle_stall", 0, st_m, 0);

    // Asynchronous reset at t+4 of a running MUL.
    step();
    drive_alu(ALU_ADD, 8'h09, 8'h09);
    ExMul = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    #1;
    check("rst_mid_pre_stall", 0, st_m, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_stall", 0, st_m, 0);
    check("rst_mid_valid", 0, ov_m, 0);
    ExMul = 1'b0; ExValid = 1'b0;
    step();
    #2 reset = 1'b1;
    step();
    drive_alu(ALU_ADD, 8'h05, 8'h06);
    #1;
    check("rst_mid_idle_valid", 0, ov_m, 1);
    check("rst_mid_idle_stall", 0, st_m, 0);
    ExValid = 1'b0;
    bad = 0;
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (ov_m !== 1'b0 || st_m !== 1'b0) bad++;
    end
    check("rst_mid_no_late_pulse", 0, bad, 0);

    // MUL_EN=0 build executes ExALUOp in one cycle even with ExMul set.
    step();
    drive_alu(ALU_ADD, 8'h21, 8'h12);
    ExMul = 1'b1;
    #1;
    check("nomul_out", 0, out_n, 8'h33);
    check("nomul_valid", 0, ov_n, 1);
    check("nomul_stall", 0, st_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
- Parametrised, multi-cycle successor to the pipelined CPU's execute stage.
- Keeps operand forwarding, ALU-source selection, single-cycle ALU ops and CBZ zero detection.
- Adds an iterative shift-add multiplier (MUL) that stalls the pipeline through a stall/done handshake with the hazard unit.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
- WIDTH, 64, datapath width in bits (>=8).
- MUL_EN, 1, 1 = MUL supported; 0 = ExMul ignored and the multiplier is not instantiated.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ExValid  in  1  a valid instruction occupies EX this cycle.
- ExMul  in  1  the instruction is MUL (overrides ExALUOp).
- ExFlush  in  1  kill the EX instruction (branch mispredict).
- ExDa, ExDb  in  WIDTH  register-file operands.
- ExImm12Ext, ExImm9Ext  in  WIDTH  sign/zero-extended immediates.
- MemALUOut, WbMemDataToReg  in  WIDTH  forwarding sources.
- ForwardDa, ForwardDb  in  2  forwarding selects: 0 = Ex operand, 1 = MemALUOut, 2 = WbMemDataToReg, 3 = 0.
- ExALUSrc  in  2  ALU B source: 0 = FwdDb, 1 = Imm12, 2 = Imm9, 3 = 0.
- ExALUOp  in  3  000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor; others yield 0.
- ExALUOut  out  WIDTH  result.
- ExFwdDb  out  WIDTH  forwarded Db (store data).
- ExNegative, ExZero, ExOverflow, ExCarryout  out  1  flags.
- ExStall  out  1  hold IF/ID/EX and bubble into MEM.
- ExOutValid  out  1  ExALUOut is valid for EX/MEM capture this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE; counter, multiplicand, multiplier and product registers clear to 0.
  - ExStall=0, ExOutValid=0. The combinational outputs follow the inputs as in IDLE.
- Forwarding and ALU-source muxes are always combinational. ExFwdDb = forwarded Db in every state.
- ExZero = (FwdDb == 0), for CBZ. This holds for all ops, including MUL.
- ALU ops (IDLE, ExMul=0):
  - Zero latency. ExOutValid = ExValid & ~ExFlush. ExStall=0.
  - ExNegative = result MSB.
  - Add/sub: two's complement modulo 2^WIDTH. ExCarryout = carry out of the MSB (sub is A + ~B + 1). ExOverflow = signed overflow.
  - Logic/pass ops: ExOverflow=0, ExCarryout=0.
- State machine {IDLE, RUN, DONE}:
  - IDLE, with ExValid & ExMul & ~ExFlush & MUL_EN:
    - ExStall=1 and ExOutValid=0 combinationally.
    - On the clock edge: latch FwdDa as multiplicand and the ALU-B mux output as multiplier; product←0; cnt←WIDTH; go to RUN.
  - RUN:
    - ExStall=1, ExOutValid=0.
    - Each cycle: if multiplier[0], product += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt--.
    - When cnt reaches 1 on this edge, go to DONE. RUN therefore lasts exactly WIDTH cycles.
  - DONE:
    - ExStall=0, ExOutValid=1, ExALUOut = product (low WIDTH bits; the upper half is discarded).
    - ExNegative = product MSB; ExOverflow=0; ExCarryout=0.
    - Next state is IDLE unconditionally. ExMul still asserted by the held instruction is ignored, so there is no restart.
- Timing: a MUL issued in cycle t has ExStall high in cycles t..t+WIDTH and its result in cycle t+WIDTH+1. The stall is WIDTH+1 cycles.
- During RUN, the live operand and forwarding inputs may change; the latched operands are used.
- ExFlush in any state:
  - ExOutValid=0 and ExStall=0 that cycle; next state IDLE.
  - Flush has priority over MUL issue in the same cycle.
- Reset asserted mid-RUN aborts immediately. No partial result is ever emitted.
- MUL_EN=0: ExMul is ignored and the instruction executes ExALUOp.

Decomposition:
- Package exec_pkg: ALU op encodings, forward-select and ALUSrc encodings, typedef enum exec_state_t {IDLE, RUN, DONE}.
- Sub-module mul_iter:
  - Parametrised by WIDTH.
  - Ports: start, operands, abort, busy, done, product.
  - Contains the counter and shift-add datapath.
- execute_stage_mc holds the muxes, ALU, flag logic and the handshake FSM wrapper.

Test Plan:
1. WIDTH=8, add, ForwardDa=1, MemALUOut=0x7F, ExDb=0x01, ALUSrc=0 -> ExALUOut=0x80, ExOverflow=1, ExNegative=1, ExCarryout=0, ExOutValid=1 same cycle, ExStall=0.
2. WIDTH=8, sub, A=0x05, Imm12=0x05, ALUSrc=1 -> ExALUOut=0x00, ExCarryout=1, ExOverflow=0. Separately, ExDb=0 gives ExZero=1.
3. WIDTH=8, MUL 0x0D×0x0B issued at cycle t -> ExStall=1 for cycles t..t+8; cycle t+9 ExALUOut=0x8F (143), ExOutValid=1, ExStall=0; IDLE at t+10. Toggling ForwardDa/ExDa during RUN leaves the result unchanged.
4. WIDTH=8, MUL 0x10×0x10 -> ExALUOut=0x00 (truncated), ExNegative=0, ExOverflow=0. Back-to-back MUL issued in the cycle after DONE restarts correctly.
5. MUL issued, then ExFlush asserted at t+3 -> ExStall=0 and ExOutValid=0 that cycle; IDLE next cycle; no ExOutValid pulse afterwards.
6. reset driven low asynchronously at t+4 mid-MUL -> ExStall=0 immediately, state IDLE. MUL_EN=0 build: ExMul=1 with ALUOp=add gives the add result in a single cycle.
